// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle; divide-by-zero
// and signed overflow complete in a single cycle. Optional build macro
// MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle
// combinational multiplier (IDLE -> FIX -> DONE).
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_req,
  output logic [31:0] result,
  output logic        result_valid
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic        r_s1;
  logic        r_s2;
  logic [31:0] r_b;        // multiplicand or divisor magnitude
  logic [63:0] r_acc;      // {hi, multiplier} or {rem, quot}
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_valid;

  // Capture-cycle decode
  logic        w_accept;
  logic        w_sgn1_en;
  logic        w_sgn2_en;
  logic        w_s1;
  logic        w_s2;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic [31:0] w_special_res;

  assign w_accept      = (r_state == S_IDLE) && start && !flush;
  assign w_sgn1_en     = !(op == 3'd3) && !(op[2] && op[0]);
  assign w_sgn2_en     = w_sgn1_en && (op != 3'd2);
  assign w_s1          = src1[31] & w_sgn1_en;
  assign w_s2          = src2[31] & w_sgn2_en;
  assign w_abs1        = w_s1 ? -src1 : src1;
  assign w_abs2        = w_s2 ? -src2 : src2;
  assign w_div0        = (src2 == '0);
  assign w_ovf         = op[2] && !op[0] && (src1 == 32'h8000_0000) && (src2 == '1);
  assign w_special     = op[2] && (w_div0 || w_ovf);
  assign w_special_res = w_div0 ? (op[1] ? src1 : '1) : (op[1] ? '0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_fast_prod;
  assign w_fast_prod = {32'b0, w_abs1} * {32'b0, w_abs2};
`endif

  // One shift-add multiply step: add into the upper half, shift right
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

  // One restoring divide step: shifted remainder is 33 bits wide
  logic [32:0] w_rem_sh;
  logic        w_keep;
  logic [31:0] w_diff;
  logic [63:0] w_div_nxt;
  assign w_rem_sh  = r_acc[63:31];
  assign w_keep    = (w_rem_sh >= {1'b0, r_b});
  assign w_diff    = w_rem_sh[31:0] - r_b;
  assign w_div_nxt = w_keep ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

  // Sign correction and result select
  logic        w_neg;
  logic [63:0] w_prod;
  logic [31:0] w_divsel;
  logic [31:0] w_divres;
  logic [31:0] w_fix_res;
  assign w_neg     = (r_op[2] && r_op[1]) ? r_s1 : (r_s1 ^ r_s2);
  assign w_prod    = w_neg ? -r_acc : r_acc;
  assign w_divsel  = r_op[1] ? r_acc[63:32] : r_acc[31:0];
  assign w_divres  = w_neg ? -w_divsel : w_divsel;
  assign w_fix_res = r_op[2] ? w_divres : ((r_op == 3'd0) ? w_prod[31:0] : w_prod[63:32]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op[2])
            w_next = w_special ? S_DONE : S_DIV;
          else
`ifdef MULDIV_FAST_MUL_EN
            w_next = S_FIX;
`else
            w_next = S_MUL;
`endif
        end
      end
      S_MUL:   if (r_cnt == 6'd31) w_next = S_FIX;
      S_DIV:   if (r_cnt == 6'd31) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (!hold) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Stall output: busy states, plus the accepting IDLE cycle
  always_comb begin
    stall_req = 1'b0;
    case (r_state)
      S_IDLE:                stall_req = start && !flush;
      S_MUL, S_DIV, S_FIX:   stall_req = 1'b1;
      default:               stall_req = 1'b0;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_s1  <= w_s1;
            r_s2  <= w_s2;
            r_b   <= w_abs2;
            r_cnt <= '0;
`ifdef MULDIV_FAST_MUL_EN
            r_acc <= op[2] ? {32'b0, w_abs1} : w_fast_prod;
`else
            r_acc <= {32'b0, w_abs1};
`endif
            if (w_special) r_result <= w_special_res;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + 6'd1;
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX:   r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  // Registered valid, high exactly while in DONE
  always_ff @(posedge clk) begin
    if (rst) r_valid <= 1'b0;
    else     r_valid <= (w_next == S_DONE);
  end

  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv. The driver pushes the
// reference-model result on every issued op; an independent monitor pops and
// compares on each rising edge of result_valid and checks stability in hold.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        hold;
  logic        stall_req;
  logic [31:0] result;
  logic        result_valid;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .src1         (src1),
    .src2         (src2),
    .flush        (flush),
    .hold         (hold),
    .stall_req    (stall_req),
    .result       (result),
    .result_valid (result_valid)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 2;
`else
  localparam int unsigned MUL_LAT = 34;
`endif

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin sp = sa * sb; p = sp; return p[31:0]; end
      3'd1: begin sp = sa * sb; p = sp; return p[63:32]; end
      3'd2: begin sp = sa * longint'({32'b0, b}); p = sp; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; p = sp; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; p = sp; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4) begin
      if (b == 32'd0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
    end
    return MUL_LAT;
  endfunction

  // Monitor: compare on each new result, check stability while held
  logic        prev_v  = 1'b0;
  logic [31:0] cur_exp = '0;
  logic        mon_en  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (result_valid && !prev_v) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_valid: got result_valid=1 with %08h, required no result at %0t", result, $time);
          end else begin
            cur_exp = sb_q.pop_front();
            chk("result", result, cur_exp);
          end
        end else if (result_valid) begin
          chk("result_held", result, cur_exp);
        end
      end
      prev_v = result_valid;
    end
  end

  // Issue one op, hold DONE for nhold cycles, check timing and stall behaviour
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int unsigned nhold);
    int unsigned lat, stalls, vcnt, hleft, le;
    bit          done;
    le = exp_lat(f, a, b);
    @(negedge clk);
    start = 1'b1; op = f; src1 = a; src2 = b; hold = 1'b0; flush = 1'b0;
    sb_q.push_back(model(f, a, b));
    #1;
    chk("idle_valid_low", {31'b0, result_valid}, 32'd0);
    lat = 0; stalls = 0; vcnt = 0; hleft = nhold; done = 1'b0;
    for (int unsigned k = 0; k < 200 && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (k == 1) begin
        src1 = $urandom;
        src2 = $urandom;
      end
      if (result_valid) begin
        if (vcnt == 0) lat = k;
        vcnt++;
        chk("done_stall_low", {31'b0, stall_req}, 32'd0);
        if (hleft > 0) begin
          hold = 1'b1;
          hleft--;
        end else begin
          hold = 1'b0;
          done = 1'b1;
        end
      end else if (stall_req) begin
        stalls++;
      end
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: op %0d got no result within 200 cycles, required %0d", f, le);
    end
    chk("latency", lat, le);
    chk("stall_cycles", stalls, le);
    chk("valid_cycles", vcnt, nhold + 1);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; hold = 1'b0; flush = 1'b0;
      src1 = $urandom; src2 = $urandom;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; src1 = '0; src2 = '0; flush = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_valid", {31'b0, result_valid}, 32'd0);
    chk("reset_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed vectors
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 3);
    do_op(3'd5, 32'd9, 32'd0, 3);
    idle(2);

    // Flush in cycle 10 of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'h0BAD_F00D; src2 = 32'd9;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_stall", {31'b0, stall_req}, 32'd0);
    chk("flush_valid", {31'b0, result_valid}, 32'd0);
    idle(40);
    chk("flush_no_result", {31'b0, result_valid}, 32'd0);
    do_op(3'd6, 32'h0BAD_F00D, 32'd9, 0);

    // Reset in cycle 5 of a multiply
    @(negedge clk);
    start = 1'b1; op = 3'd0; src1 = 32'h0000_1234; src2 = 32'h0000_5678;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall_req}, 32'd0);
    idle(1);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);

    // Randomized ops, some back-to-back, some with idle gaps and holds
    for (int unsigned i = 0; i < 60; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      do_op(rf, ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
